// File: rtl/icache_setassoc.sv
// Set-associative, read-only instruction cache between a CPU fetch port and
// an AHB-Lite instruction bus. Hits return data one cycle after the fetch is
// accepted; misses refill a whole line with a line-aligned incrementing burst.
// CPU hit-invalidate clears the matching way of a resident line.
// Optional build feature: define ICACHE_PERF_CNT_EN to add the perf_hit and
// perf_miss counter output ports.
module icache_setassoc #(
    parameter int LINE_WIDTH  = 6,
    parameter int INDEX_WIDTH = 4,
    parameter int WAYS_LOG2   = 1
) (
    input  logic        clk,
    input  logic        nrst,
    output logic [31:0] AHB_haddr,
    output logic [2:0]  AHB_hburst,
    output logic [3:0]  AHB_hprot,
    output logic [2:0]  AHB_hsize,
    output logic [1:0]  AHB_htrans,
    output logic        AHB_hwrite,
    output logic [31:0] AHB_hwdata,
    output logic        AHB_sel,
    output logic        AHB_hready_in,
    input  logic        AHB_hready_out,
    input  logic        AHB_hresp,
    input  logic [31:0] AHB_hrdata,
    input  logic        dbus_read,
    input  logic [31:0] dbus_rdaddr,
    output logic [31:0] dbus_rddata,
    output logic        dbus_rdstall,
    input  logic        dbus_hitinvalidate,
    input  logic [31:0] dbus_ivaddr,
    output logic        dbus_ivstall
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] perf_hit,
    output logic [31:0] perf_miss
`endif
);

    localparam int TAG_WIDTH = 32 - INDEX_WIDTH - LINE_WIDTH;
    localparam int OFF_WIDTH = LINE_WIDTH - 2;
    localparam int SETS      = 1 << INDEX_WIDTH;
    localparam int WORDS     = 1 << OFF_WIDTH;
    localparam int WAYS      = 1 << WAYS_LOG2;
    localparam int WAY_W     = (WAYS_LOG2 == 0) ? 1 : WAYS_LOG2;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_CFG = (LINE_WIDTH == 4) ? 3'b011 :
                                        (LINE_WIDTH == 5) ? 3'b101 : 3'b111;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_FILL  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_INVAL = 3'd4;

    localparam logic [OFF_WIDTH-1:0] OFF_ZERO = {OFF_WIDTH{1'b0}};
    localparam logic [OFF_WIDTH-1:0] OFF_LAST = {OFF_WIDTH{1'b1}};

    // Storage: data and tags need no reset, only the valid bits do.
    logic [31:0]          data_r  [WAYS][SETS][WORDS];
    logic [TAG_WIDTH-1:0] tag_r   [WAYS][SETS];
    logic [WAYS-1:0]      valid_r [SETS];
    logic [WAY_W-1:0]     rr_r    [SETS];

    logic [2:0]           state_r;
    logic [1:0]           htrans_r;
    logic                 sel_r;
    logic [OFF_WIDTH-1:0] addr_off_r;
    logic [OFF_WIDTH-1:0] data_off_r;
    logic [TAG_WIDTH-1:0] fill_tag_r;
    logic [INDEX_WIDTH-1:0] fill_idx_r;
    logic [WAY_W-1:0]     victim_r;
    logic                 victim_valid_r;
    logic [WAY_W-1:0]     iv_way_r;
    logic [INDEX_WIDTH-1:0] iv_idx_r;
    logic [31:0]          rddata_r;

    logic [INDEX_WIDTH-1:0] rd_idx_s;
    logic [TAG_WIDTH-1:0]   rd_tag_s;
    logic [OFF_WIDTH-1:0]   rd_off_s;
    logic [INDEX_WIDTH-1:0] iv_idx_s;
    logic [TAG_WIDTH-1:0]   iv_tag_s;
    logic [WAYS-1:0]        rd_hit_vec_s;
    logic [WAYS-1:0]        iv_hit_vec_s;
    logic                   rd_hit_s;
    logic                   iv_hit_s;
    logic [WAY_W-1:0]       rd_way_s;
    logic [WAY_W-1:0]       iv_way_s;
    logic [WAY_W-1:0]       victim_s;
    logic                   set_full_s;
    logic                   rdstall_s;
    logic                   ivstall_s;
    logic                   fetch_acc_s;
    logic                   start_fill_s;
    logic                   data_we_s;
    logic                   unused_addr_bits_s;

    // Index of the lowest set bit; zero when no bit is set.
    function automatic logic [WAY_W-1:0] lowest_way(input logic [WAYS-1:0] vec);
        logic [WAY_W-1:0] enc;
        enc = {WAY_W{1'b0}};
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (vec[w]) begin
                enc = WAY_W'(w);
            end else begin
                enc = enc;
            end
        end
        return enc;
    endfunction

    // Round-robin successor, wrapping modulo the number of ways.
    function automatic logic [WAY_W-1:0] rr_inc(input logic [WAY_W-1:0] ptr);
        if (WAYS_LOG2 == 0) begin
            return {WAY_W{1'b0}};
        end else begin
            return ptr + WAY_W'(1'b1);
        end
    endfunction

    assign rd_idx_s = dbus_rdaddr[LINE_WIDTH +: INDEX_WIDTH];
    assign rd_tag_s = dbus_rdaddr[LINE_WIDTH + INDEX_WIDTH +: TAG_WIDTH];
    assign rd_off_s = dbus_rdaddr[2 +: OFF_WIDTH];
    assign iv_idx_s = dbus_ivaddr[LINE_WIDTH +: INDEX_WIDTH];
    assign iv_tag_s = dbus_ivaddr[LINE_WIDTH + INDEX_WIDTH +: TAG_WIDTH];
    assign unused_addr_bits_s = ^{dbus_rdaddr[1:0], dbus_ivaddr[LINE_WIDTH-1:0]};

    // Tag lookup for both the fetch and the invalidate address, plus victim choice.
    always_comb begin
        rd_hit_vec_s = {WAYS{1'b0}};
        iv_hit_vec_s = {WAYS{1'b0}};
        for (int w = 0; w < WAYS; w++) begin
            rd_hit_vec_s[w] = valid_r[rd_idx_s][w] && (tag_r[w][rd_idx_s] == rd_tag_s);
            iv_hit_vec_s[w] = valid_r[iv_idx_s][w] && (tag_r[w][iv_idx_s] == iv_tag_s);
        end
        rd_hit_s   = |rd_hit_vec_s;
        iv_hit_s   = dbus_hitinvalidate && (|iv_hit_vec_s);
        rd_way_s   = lowest_way(rd_hit_vec_s);
        iv_way_s   = lowest_way(iv_hit_vec_s);
        set_full_s = &valid_r[rd_idx_s];
        if (set_full_s) begin
            victim_s = rr_r[rd_idx_s];
        end else begin
            victim_s = lowest_way(~valid_r[rd_idx_s]);
        end
    end

    // Stall and handshake qualifiers seen by the CPU side.
    always_comb begin
        rdstall_s = (state_r != ST_IDLE) ||
                    (dbus_read && !rd_hit_s) ||
                    (iv_hit_s && (dbus_ivaddr[31:2] == dbus_rdaddr[31:2]));
        ivstall_s = (state_r != ST_IDLE) || iv_hit_s;
        fetch_acc_s  = dbus_read && !rdstall_s;
        start_fill_s = (state_r == ST_IDLE) && !iv_hit_s && dbus_read && !rd_hit_s;
        data_we_s    = (state_r == ST_FILL) && AHB_hready_out && !AHB_hresp;
    end

    // Control FSM, refill bus sequencing, valid bits, RR pointers and read data.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r        <= ST_IDLE;
            htrans_r       <= HTRANS_IDLE;
            sel_r          <= 1'b0;
            addr_off_r     <= OFF_ZERO;
            data_off_r     <= OFF_ZERO;
            fill_tag_r     <= {TAG_WIDTH{1'b0}};
            fill_idx_r     <= {INDEX_WIDTH{1'b0}};
            victim_r       <= {WAY_W{1'b0}};
            victim_valid_r <= 1'b0;
            iv_way_r       <= {WAY_W{1'b0}};
            iv_idx_r       <= {INDEX_WIDTH{1'b0}};
            rddata_r       <= 32'h0000_0000;
            for (int s = 0; s < SETS; s++) begin
                valid_r[s] <= {WAYS{1'b0}};
                rr_r[s]    <= {WAY_W{1'b0}};
            end
        end else begin
            if (fetch_acc_s) begin
                rddata_r <= data_r[rd_way_s][rd_idx_s][rd_off_s];
            end
            case (state_r)
                ST_IDLE: begin
                    if (iv_hit_s) begin
                        state_r  <= ST_INVAL;
                        iv_way_r <= iv_way_s;
                        iv_idx_r <= iv_idx_s;
                    end else if (start_fill_s) begin
                        state_r        <= ST_REQ;
                        fill_tag_r     <= rd_tag_s;
                        fill_idx_r     <= rd_idx_s;
                        victim_r       <= victim_s;
                        victim_valid_r <= set_full_s;
                        // The victim stays invalid until the whole line has arrived.
                        valid_r[rd_idx_s][victim_s] <= 1'b0;
                        htrans_r   <= HTRANS_NONSEQ;
                        sel_r      <= 1'b1;
                        addr_off_r <= OFF_ZERO;
                        data_off_r <= OFF_ZERO;
                    end
                end
                ST_INVAL: begin
                    valid_r[iv_idx_r][iv_way_r] <= 1'b0;
                    state_r <= ST_IDLE;
                end
                ST_REQ: begin
                    if (AHB_hresp) begin
                        state_r  <= ST_IDLE;
                        htrans_r <= HTRANS_IDLE;
                        sel_r    <= 1'b0;
                    end else if (AHB_hready_out) begin
                        state_r    <= ST_FILL;
                        htrans_r   <= HTRANS_SEQ;
                        addr_off_r <= addr_off_r + OFF_WIDTH'(1'b1);
                    end
                end
                ST_FILL: begin
                    if (AHB_hresp) begin
                        state_r  <= ST_IDLE;
                        htrans_r <= HTRANS_IDLE;
                        sel_r    <= 1'b0;
                    end else if (AHB_hready_out) begin
                        data_off_r <= data_off_r + OFF_WIDTH'(1'b1);
                        if (htrans_r != HTRANS_IDLE) begin
                            if (addr_off_r == OFF_LAST) begin
                                htrans_r <= HTRANS_IDLE;
                            end else begin
                                htrans_r   <= HTRANS_SEQ;
                                addr_off_r <= addr_off_r + OFF_WIDTH'(1'b1);
                            end
                        end
                        if (data_off_r == OFF_LAST) begin
                            state_r  <= ST_DONE;
                            htrans_r <= HTRANS_IDLE;
                            sel_r    <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    valid_r[fill_idx_r][victim_r] <= 1'b1;
                    if (victim_valid_r) begin
                        rr_r[fill_idx_r] <= rr_inc(rr_r[fill_idx_r]);
                    end
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    htrans_r <= HTRANS_IDLE;
                    sel_r    <= 1'b0;
                end
            endcase
        end
    end

    // Line data and tag storage written by the refill engine.
    always_ff @(posedge clk) begin
        if (data_we_s) begin
            data_r[victim_r][fill_idx_r][data_off_r] <= AHB_hrdata;
        end
        if (state_r == ST_DONE) begin
            tag_r[victim_r][fill_idx_r] <= fill_tag_r;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] perf_hit_r;
    logic [31:0] perf_miss_r;

    // Free-running hit/miss event counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            perf_hit_r  <= 32'h0000_0000;
            perf_miss_r <= 32'h0000_0000;
        end else begin
            if (fetch_acc_s) begin
                perf_hit_r <= perf_hit_r + 32'h0000_0001;
            end
            if (start_fill_s) begin
                perf_miss_r <= perf_miss_r + 32'h0000_0001;
            end
        end
    end

    assign perf_hit  = perf_hit_r;
    assign perf_miss = perf_miss_r;
`endif

    assign AHB_haddr     = {fill_tag_r, fill_idx_r, addr_off_r, 2'b00};
    assign AHB_hburst    = HBURST_CFG;
    assign AHB_hprot     = 4'b0011;
    assign AHB_hsize     = 3'b010;
    assign AHB_htrans    = htrans_r;
    assign AHB_hwrite    = 1'b0;
    assign AHB_hwdata    = 32'h0000_0000;
    assign AHB_sel       = sel_r;
    assign AHB_hready_in = AHB_hready_out;
    assign dbus_rddata   = rddata_r;
    assign dbus_rdstall  = rdstall_s;
    assign dbus_ivstall  = ivstall_s;

endmodule

// File: tb/tb_icache_setassoc.sv
// Scoreboard bench for icache_setassoc (LINE_WIDTH=6, INDEX_WIDTH=4, 2 ways).
// Stimulus pushes expected fetch data and expected bus address phases into
// queues; a negedge monitor pops and compares as the DUT presents them.
module tb_icache_setassoc;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
    } bus_exp_t;

    logic        clk;
    logic        nrst;
    logic [31:0] AHB_haddr;
    logic [2:0]  AHB_hburst;
    logic [3:0]  AHB_hprot;
    logic [2:0]  AHB_hsize;
    logic [1:0]  AHB_htrans;
    logic        AHB_hwrite;
    logic [31:0] AHB_hwdata;
    logic        AHB_sel;
    logic        AHB_hready_in;
    logic        AHB_hready_out;
    logic        AHB_hresp;
    logic [31:0] AHB_hrdata;
    logic        dbus_read;
    logic [31:0] dbus_rdaddr;
    logic [31:0] dbus_rddata;
    logic        dbus_rdstall;
    logic        dbus_hitinvalidate;
    logic [31:0] dbus_ivaddr;
    logic        dbus_ivstall;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] perf_hit;
    logic [31:0] perf_miss;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_rd_q [$];
    bus_exp_t    exp_bus_q [$];
    bit          rd_pend = 1'b0;
    logic [31:0] mon_e;
    bus_exp_t    mon_b;

    // Slave model state
    bit          ws_en = 1'b0;
    bit          err_armed = 1'b0;
    int          err_beat = 0;
    bit          dp_valid = 1'b0;
    logic [31:0] dp_addr = 32'h0;
    bit          s_acc;
    logic [31:0] s_addr;

    icache_setassoc dut (
        .clk(clk), .nrst(nrst),
        .AHB_haddr(AHB_haddr), .AHB_hburst(AHB_hburst), .AHB_hprot(AHB_hprot),
        .AHB_hsize(AHB_hsize), .AHB_htrans(AHB_htrans), .AHB_hwrite(AHB_hwrite),
        .AHB_hwdata(AHB_hwdata), .AHB_sel(AHB_sel), .AHB_hready_in(AHB_hready_in),
        .AHB_hready_out(AHB_hready_out), .AHB_hresp(AHB_hresp), .AHB_hrdata(AHB_hrdata),
        .dbus_read(dbus_read), .dbus_rdaddr(dbus_rdaddr), .dbus_rddata(dbus_rddata),
        .dbus_rdstall(dbus_rdstall), .dbus_hitinvalidate(dbus_hitinvalidate),
        .dbus_ivaddr(dbus_ivaddr), .dbus_ivstall(dbus_ivstall)
`ifdef ICACHE_PERF_CNT_EN
        , .perf_hit(perf_hit), .perf_miss(perf_miss)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Backing memory contents seen through the bus.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:2], 2'b00};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic push_line(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_bus_q.push_back('{addr: base + 32'(4 * i), trans: (i == 0) ? 2'b10 : 2'b11});
        end
    endtask

    task automatic wait_accept(input bit expect_hit);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        if (expect_hit) check("hit_no_stall", {31'h0, dbus_rdstall}, 32'h0);
        for (int n = 0; n < 600; n++) begin
            if (!dbus_rdstall) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL fetch_timeout: addr %h still stalled, expected acceptance", dbus_rdaddr);
        end
        @(posedge clk);
        #1;
        dbus_read = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] a, input bit miss);
        if (miss) push_line({a[31:6], 6'b0}, 16);
        exp_rd_q.push_back(mem_word({a[31:2], 2'b00}));
        dbus_read   = 1'b1;
        dbus_rdaddr = a;
        wait_accept(!miss);
    endtask

    // AHB slave: address phase captured on hready, data returned in the next phase.
    initial begin
        AHB_hready_out = 1'b1;
        AHB_hresp      = 1'b0;
        AHB_hrdata     = 32'h0;
        forever begin
            @(negedge clk);
            s_acc  = (AHB_htrans != 2'b00) && AHB_hready_out && !AHB_hresp;
            s_addr = AHB_haddr;
            @(posedge clk);
            #1;
            if (AHB_hresp) begin
                AHB_hresp = 1'b0;
                dp_valid  = 1'b0;
            end else if (AHB_hready_out) begin
                dp_valid = s_acc;
                dp_addr  = s_addr;
            end
            AHB_hready_out = ws_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (dp_valid && err_armed && (int'(dp_addr[5:2]) == err_beat)) begin
                AHB_hresp      = 1'b1;
                AHB_hready_out = 1'b0;
                err_armed      = 1'b0;
            end
            AHB_hrdata = dp_valid ? mem_word(dp_addr) : 32'h0;
        end
    end

    // Monitor: fetch data one cycle after acceptance, and every accepted address phase.
    always @(negedge clk) begin
        if (nrst) begin
            if (rd_pend) begin
                total++;
                if (exp_rd_q.size() == 0) begin
                    bad++;
                    $display("FAIL rddata: got %h with no fetch data expected", dbus_rddata);
                end else begin
                    mon_e = exp_rd_q.pop_front();
                    if (dbus_rddata !== mon_e) begin
                        bad++;
                        $display("FAIL rddata: got %h expected %h", dbus_rddata, mon_e);
                    end
                end
            end
            rd_pend = dbus_read && !dbus_rdstall;
            if ((AHB_htrans != 2'b00) && AHB_hready_out) begin
                total++;
                if (exp_bus_q.size() == 0) begin
                    bad++;
                    $display("FAIL bus_unexpected: haddr %h htrans %b, expected no traffic",
                             AHB_haddr, AHB_htrans);
                end else begin
                    mon_b = exp_bus_q.pop_front();
                    if (AHB_haddr !== mon_b.addr || AHB_htrans !== mon_b.trans ||
                        AHB_hburst !== 3'b111 || AHB_sel !== 1'b1) begin
                        bad++;
                        $display("FAIL bus_addr: got %h/%b/%b/%b expected %h/%b/111/1",
                                 AHB_haddr, AHB_htrans, AHB_hburst, AHB_sel,
                                 mon_b.addr, mon_b.trans);
                    end
                end
            end
            if ($countones(dut.rd_hit_vec_s) > 1) begin
                bad++;
                $display("FAIL multi_hit: hit vector %b, expected at most one way", dut.rd_hit_vec_s);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
`ifdef ICACHE_PERF_CNT_EN
        logic [31:0] h0;
        logic [31:0] m0;
`endif
        nrst = 1'b0;
        dbus_read = 1'b0;
        dbus_rdaddr = 32'h0;
        dbus_hitinvalidate = 1'b0;
        dbus_ivaddr = 32'h0;
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_htrans", {30'h0, AHB_htrans}, 32'h0);
        check("rst_sel", {31'h0, AHB_sel}, 32'h0);
        check("rst_rddata", dbus_rddata, 32'h0);
        check("rst_stalls", {30'h0, dbus_rdstall, dbus_ivstall}, 32'h0);
        check("static_ctrl", {AHB_hprot, AHB_hsize, AHB_hburst, AHB_hwrite, 21'h0},
              {4'b0011, 3'b010, 3'b111, 1'b0, 21'h0});
        check("hwdata", AHB_hwdata, 32'h0);
`ifdef ICACHE_PERF_CNT_EN
        check("rst_perf", perf_hit | perf_miss, 32'h0);
`endif
        @(posedge clk);
        #1;

        // 1: cold miss on word 1 of line 0x1000, with random wait states
        ws_en = 1'b1;
        do_fetch(32'h0000_1004, 1'b1);

        // 2: second way of set 0, then a re-hit on the first line
        do_fetch(32'h0000_1400, 1'b1);
        do_fetch(32'h0000_1008, 1'b0);

        // 3: round-robin replacement in a full set
        do_fetch(32'h0000_1810, 1'b1);   // replaces way 0 (0x1000), rr -> 1
        do_fetch(32'h0000_1C00, 1'b1);   // replaces way 1 (0x1400), rr -> 0
        do_fetch(32'h0000_1814, 1'b0);
        do_fetch(32'h0000_1C04, 1'b0);
        do_fetch(32'h0000_1004, 1'b1);   // replaces way 0 (0x1800), rr -> 1
        do_fetch(32'h0000_1C08, 1'b0);
        do_fetch(32'h0000_1818, 1'b1);   // replaces way 1 (0x1C00), rr -> 0
        do_fetch(32'h0000_103C, 1'b0);

        // 4: invalidate and fetch of the same line in the same cycle
        push_line(32'h0000_1000, 16);
        exp_rd_q.push_back(mem_word(32'h0000_1000));
        dbus_hitinvalidate = 1'b1;
        dbus_ivaddr = 32'h0000_1000;
        dbus_read = 1'b1;
        dbus_rdaddr = 32'h0000_1000;
        @(negedge clk);
        check("iv_same_cycle", {30'h0, dbus_ivstall, dbus_rdstall}, 32'h3);
        for (int n = 0; n < 50; n++) begin
            if (!dbus_ivstall) break;
            @(negedge clk);
        end
        check("iv_release", {31'h0, dbus_ivstall}, 32'h0);
        @(posedge clk);
        #1 dbus_hitinvalidate = 1'b0;
        wait_accept(1'b0);
        do_fetch(32'h0000_1820, 1'b0);

        // 5: bus error on data beat 3, then retry from offset 0
        ws_en = 1'b0;
        err_beat = 3;
        err_armed = 1'b1;
        push_line(32'h0000_3040, 4);
        seen = 1'b0;
        fork
            do_fetch(32'h0000_3048, 1'b1);
            begin
                for (int n = 0; n < 300; n++) begin
                    @(negedge clk);
                    if (AHB_hresp) begin
                        seen = 1'b1;
                        break;
                    end
                end
                check("err_seen", {31'h0, seen}, 32'h1);
                @(negedge clk);
                check("err_bus_idle", {29'h0, AHB_htrans, AHB_sel}, 32'h0);
            end
        join
        do_fetch(32'h0000_307C, 1'b0);

        // Invalidate of a non-resident line is accepted immediately
        dbus_hitinvalidate = 1'b1;
        dbus_ivaddr = 32'h0000_5000;
        @(negedge clk);
        check("iv_nonresident", {31'h0, dbus_ivstall}, 32'h0);
        @(posedge clk);
        #1 dbus_hitinvalidate = 1'b0;

`ifdef ICACHE_PERF_CNT_EN
        // 6: one miss plus five hits
        @(negedge clk);
        h0 = perf_hit;
        m0 = perf_miss;
        @(posedge clk);
        #1;
        do_fetch(32'h0000_4084, 1'b1);
        do_fetch(32'h0000_4080, 1'b0);
        do_fetch(32'h0000_4088, 1'b0);
        do_fetch(32'h0000_40BC, 1'b0);
        do_fetch(32'h0000_40A0, 1'b0);
        @(negedge clk);
        check("perf_miss", perf_miss - m0, 32'd1);
        check("perf_hit", perf_hit - h0, 32'd5);
`endif

        repeat (3) @(negedge clk);
        check("rd_queue_empty", 32'(exp_rd_q.size()), 32'h0);
        check("bus_queue_empty", 32'(exp_bus_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
